fuzzy_attack_fsm_mc: RTL
========================

// Module: fuzzy_attack_fsm_mc
// PURPOSE
//  Multi-channel, parametrised successor to the single-channel fuzzy SCA attack FSM.
//  Each channel receives Q3.7 power features and a Hamming distance, and computes shift-based fuzzy memberships.
//  A 2-of-3 fuzzy rule score is formed per channel; a per-channel confirm/release FSM then raises attack_detected.
//  Sits between the power-trace feature extractor and the countermeasure controller.
// PARAMETERS
//  NCH      2    number of independent channels
//  W        10   feature width, unsigned Q3.7 (energy, peak_power, mean_power)
//  HD_W     8    hamming_dist width per channel
//  E_LO     384  energy membership floor (3.0); E_SH 6: ramp spans 2^E_SH LSBs
//  C_LO     4    crest (peak-mean) floor; C_SH 3
//  H_LO     0    hamming floor; H_SH 2
//  ALARM_TH 128  score >= ALARM_TH is a "hit"
//  CONFIRM  2    consecutive hits needed to enter ALARM (1..15)
//  RELEASE  3    consecutive misses needed to leave alarm (1..15)
// PORTS
//  clk             in   1          rising-edge clock
//  rst             in   1          async active-high reset
//  clr             in   1          sync clear of FSMs/counter (not pipeline)
//  in_valid        in   1          all channel inputs valid this cycle
//  energy          in   NCH*W      ch i at [i*W +: W]
//  peak_power      in   NCH*W      per channel
//  mean_power      in   NCH*W      per channel
//  hamming_dist    in   NCH*HD_W   per channel
//  score_valid     out  1          score bus valid
//  score           out  NCH*8      per-channel fuzzy score 0..255
//  attack_detected out  NCH        per-channel alarm (ALARM or COOLDOWN)
//  attack_any      out  1          OR of attack_detected
//  alarm_events    out  16         saturating count of entries into ALARM
// BEHAVIOUR
//  Reset: all outputs 0, all FSMs IDLE, all counters 0, pipeline valids 0.
//  Stage 1 (edge k, in_valid=1): crest = peak-mean, saturated to 0 if mean>peak.
//   mu(x,LO,SH) = 0 if x<=LO; 255 if x-LO >= 2^SH; else (x-LO)<<(8-SH). All mu are 8-bit.
//  Stage 2 (edge k+1): r1=min(muE,muC), r2=min(muC,muH), r3=min(muE,muH).
//   score=max(r1,r2,r3); score_valid=1 for exactly one cycle per accepted sample.
//  Stage 3 (edge k+2): each channel FSM steps only when score_valid=1; otherwise it holds.
//   IDLE: hit -> SUSPECT, cnt=1 (CONFIRM=1: directly ALARM). Miss stays IDLE.
//   SUSPECT: hit -> cnt+1; cnt+1==CONFIRM -> ALARM, cnt=0. Miss -> IDLE, cnt=0.
//   ALARM: hit stays. Miss -> COOLDOWN, cnt=1 (RELEASE=1: directly IDLE).
//   COOLDOWN: miss -> cnt+1; cnt+1==RELEASE -> IDLE. Hit -> ALARM, cnt=0.
//  attack_detected[i]=1 in ALARM or COOLDOWN. Latency from input sample to flag is 3 edges.
//  alarm_events += number of channels entering ALARM from IDLE/SUSPECT on the same edge.
//   It saturates at 16'hFFFF and never wraps.
//  in_valid on back-to-back cycles is fully pipelined, with no stall.
//  clr: FSMs -> IDLE, cnt and alarm_events -> 0 on the next edge.
//   clr has priority over a coincident score_valid. Stages 1-2 still propagate.
//  rst asserted mid-sample drops any in-flight samples; no score_valid is emitted for them.
// TESTING
//  1) ch0 E=389,P=10,M=7,H=0 -> muE=20, crest 3 muC=0, muH=0; score 0, no alarm.
//  2) ch0 E=441,P=20,M=7,H=7 twice -> score 255 each.
//     attack_detected[0]=1 three edges after 2nd sample; alarm_events=1.
//  3) After 2): E=368,P=10,M=7,H=0 x3 -> flag held through 2 misses, cleared on 3rd (RELEASE).
//  4) ch0 attack then normal then attack (CONFIRM=2) -> never alarms.
//     Same sequence on ch1 with E=463,P=21,M=7,H=4 twice -> ch1 alarms only; attack_any=1.
//  5) Both channels enter ALARM on the same edge -> alarm_events +2.
//     Preload near 16'hFFFF -> saturates at FFFF.
//  6) Async rst mid-stream and clr during ALARM -> outputs 0.
//     score_valid is not seen for dropped samples; clr beats coincident hit.

Source files
------------

// File: rtl/fuzzy_attack_fsm_mc.sv
// fuzzy_attack_fsm_mc: multi-channel fuzzy side-channel attack detector.
//   Each channel turns Q3.7 energy / crest (peak-mean) / Hamming distance into
//   8-bit ramp memberships, forms a 2-of-3 fuzzy score, and drives a
//   confirm/release FSM whose ALARM/COOLDOWN states raise attack_detected.
// Latency: 3 clk edges from an accepted sample to its effect on attack_detected.
// Backpressure: none. in_valid may be asserted every cycle and is never stalled.
// Ports:
//   clk, rst (async, active high), clr (sync clear of FSMs and event counter)
//   in_valid, energy/peak_power/mean_power [NCH*W], hamming_dist [NCH*HD_W]
//   score_valid, score [NCH*8], attack_detected [NCH], attack_any, alarm_events [16]
module fuzzy_attack_fsm_mc #(
    parameter int NCH      = 2,
    parameter int W        = 10,
    parameter int HD_W     = 8,
    parameter int E_LO     = 384,
    parameter int E_SH     = 6,
    parameter int C_LO     = 4,
    parameter int C_SH     = 3,
    parameter int H_LO     = 0,
    parameter int H_SH     = 2,
    parameter int ALARM_TH = 128,
    parameter int CONFIRM  = 2,
    parameter int RELEASE  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [NCH*W-1:0]     energy,
    input  logic [NCH*W-1:0]     peak_power,
    input  logic [NCH*W-1:0]     mean_power,
    input  logic [NCH*HD_W-1:0]  hamming_dist,
    output logic                 score_valid,
    output logic [NCH*8-1:0]     score,
    output logic [NCH-1:0]       attack_detected,
    output logic                 attack_any,
    output logic [15:0]          alarm_events
);

    typedef enum logic [1:0] {ST_IDLE, ST_SUSPECT, ST_ALARM, ST_COOLDOWN} state_t;

    // Ramp membership: 0 at or below lo, full scale once 2^sh above lo,
    // linear in between by shifting the offset up to the 8-bit range.
    function automatic logic [7:0] mu(input logic [31:0] x, input int lo, input int sh);
        logic [31:0] d;
        if (x <= 32'(lo)) return 8'd0;
        d = x - 32'(lo);
        if (d >= (32'd1 << sh)) return 8'hFF;
        return 8'(d << (8 - sh));
    endfunction

    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // ---------------- Stage 1: memberships ----------------
    logic [NCH-1:0][W-1:0] crest;
    logic [NCH-1:0][7:0]   mu_e_d, mu_c_d, mu_h_d;
    logic [NCH-1:0][7:0]   mu_e_q, mu_c_q, mu_h_q;
    logic                  s1_vld_q;

    always_comb begin
        crest  = '0;
        mu_e_d = '0;
        mu_c_d = '0;
        mu_h_d = '0;
        for (int i = 0; i < NCH; i++) begin
            // Mean above peak is a glitch in the extractor; treat crest as zero
            // instead of letting the subtraction wrap to a huge value.
            crest[i]  = (mean_power[i*W +: W] > peak_power[i*W +: W]) ? '0
                      : peak_power[i*W +: W] - mean_power[i*W +: W];
            mu_e_d[i] = mu(32'(energy[i*W +: W]), E_LO, E_SH);
            mu_c_d[i] = mu(32'(crest[i]), C_LO, C_SH);
            mu_h_d[i] = mu(32'(hamming_dist[i*HD_W +: HD_W]), H_LO, H_SH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            mu_e_q   <= '0;
            mu_c_q   <= '0;
            mu_h_q   <= '0;
        end else begin
            s1_vld_q <= in_valid;
            if (in_valid) begin
                mu_e_q <= mu_e_d;
                mu_c_q <= mu_c_d;
                mu_h_q <= mu_h_d;
            end
        end
    end

    // ---------------- Stage 2: 2-of-3 rule score ----------------
    logic [NCH-1:0][7:0] score_d, score_q;
    logic                score_vld_q;

    always_comb begin
        score_d = '0;
        for (int i = 0; i < NCH; i++) begin
            score_d[i] = max8(max8(min8(mu_e_q[i], mu_c_q[i]),
                                   min8(mu_c_q[i], mu_h_q[i])),
                              min8(mu_e_q[i], mu_h_q[i]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_vld_q <= 1'b0;
            score_q     <= '0;
        end else begin
            score_vld_q <= s1_vld_q;
            if (s1_vld_q) score_q <= score_d;
        end
    end

    // ---------------- Stage 3: confirm/release FSMs ----------------
    state_t          state_q [NCH];
    state_t          state_d [NCH];
    logic [3:0]      cnt_q   [NCH];
    logic [3:0]      cnt_d   [NCH];
    logic [NCH-1:0]  hit;
    logic [7:0]      n_enter;
    logic [16:0]     evt_sum;
    logic [15:0]     alarm_events_q, alarm_events_d;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NCH; i++) hit[i] = (32'(score_q[i]) >= 32'(ALARM_TH));
    end

    always_comb begin
        n_enter = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (clr) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else if (score_vld_q) begin
                case (state_q[i])
                    ST_IDLE: if (hit[i]) begin
                        if (CONFIRM == 1) begin
                            state_d[i] = ST_ALARM;
                            cnt_d[i]   = '0;
                            n_enter    = n_enter + 8'd1;
                        end else begin
                            state_d[i] = ST_SUSPECT;
                            cnt_d[i]   = 4'd1;
                        end
                    end
                    ST_SUSPECT: if (hit[i]) begin
                        if ((cnt_q[i] + 4'd1) == 4'(CONFIRM)) begin
                            state_d[i] = ST_ALARM;
                            cnt_d[i]   = '0;
                            n_enter    = n_enter + 8'd1;
                        end else begin
                            cnt_d[i]   = cnt_q[i] + 4'd1;
                        end
                    end else begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                    ST_ALARM: if (!hit[i]) begin
                        if (RELEASE == 1) begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            state_d[i] = ST_COOLDOWN;
                            cnt_d[i]   = 4'd1;
                        end
                    end
                    ST_COOLDOWN: if (hit[i]) begin
                        // Re-arming from cooldown is not a new alarm event.
                        state_d[i] = ST_ALARM;
                        cnt_d[i]   = '0;
                    end else if ((cnt_q[i] + 4'd1) == 4'(RELEASE)) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + 4'd1;
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Saturating add: a 17th bit catches the carry so the count sticks at FFFF.
    assign evt_sum = {1'b0, alarm_events_q} + {9'd0, n_enter};

    always_comb begin
        alarm_events_d = alarm_events_q;
        if (clr)             alarm_events_d = '0;
        else if (evt_sum[16]) alarm_events_d = 16'hFFFF;
        else                 alarm_events_d = evt_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            alarm_events_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            alarm_events_q <= alarm_events_d;
        end
    end

    always_comb begin
        attack_detected = '0;
        for (int i = 0; i < NCH; i++)
            attack_detected[i] = (state_q[i] == ST_ALARM) || (state_q[i] == ST_COOLDOWN);
    end

    assign attack_any   = |attack_detected;
    assign score_valid  = score_vld_q;
    assign score        = score_q;
    assign alarm_events = alarm_events_q;

endmodule
